// File: rtl/alu_pkg.sv
// Shared ALU definitions: function indices, opcode encodings, latency classes
// and the issue-controller state type.
package alu_pkg;

  localparam int NUM_FUNC = 15;

  localparam logic [3:0] FUNC_ADD  = 4'd0;
  localparam logic [3:0] FUNC_SUB  = 4'd1;
  localparam logic [3:0] FUNC_MUL  = 4'd2;
  localparam logic [3:0] FUNC_DIV  = 4'd3;
  localparam logic [3:0] FUNC_MOD  = 4'd4;
  localparam logic [3:0] FUNC_MAX  = 4'd5;
  localparam logic [3:0] FUNC_MIN  = 4'd6;
  localparam logic [3:0] FUNC_NOT  = 4'd7;
  localparam logic [3:0] FUNC_NAND = 4'd8;
  localparam logic [3:0] FUNC_XNOR = 4'd9;
  localparam logic [3:0] FUNC_SHL  = 4'd10;
  localparam logic [3:0] FUNC_SHRL = 4'd11;
  localparam logic [3:0] FUNC_ROL  = 4'd12;
  localparam logic [3:0] FUNC_ROR  = 4'd13;
  localparam logic [3:0] FUNC_SLT  = 4'd14;

  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_MUL   = 5'b00011;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_MOD   = 5'b00101;
  localparam logic [4:0] OP_MAX   = 5'b00110;
  localparam logic [4:0] OP_MIN   = 5'b00111;
  localparam logic [4:0] OP_NOT   = 5'b01000;
  localparam logic [4:0] OP_NAND  = 5'b01001;
  localparam logic [4:0] OP_XNOR  = 5'b01010;
  localparam logic [4:0] OP_SHL   = 5'b01011;
  localparam logic [4:0] OP_SHRL  = 5'b01100;
  localparam logic [4:0] OP_ROL   = 5'b01101;
  localparam logic [4:0] OP_ROR   = 5'b01110;
  localparam logic [4:0] OP_SLT   = 5'b01111;

  localparam logic [4:0] OP_ADDI  = 5'b10010;
  localparam logic [4:0] OP_SUBI  = 5'b10011;
  localparam logic [4:0] OP_MULI  = 5'b10100;
  localparam logic [4:0] OP_DIVI  = 5'b10101;
  localparam logic [4:0] OP_NANDI = 5'b10110;
  localparam logic [4:0] OP_XNORI = 5'b10111;

  typedef enum logic [1:0] {LAT_1, LAT_MUL, LAT_DIV} lat_class_e;

  typedef enum logic {ST_IDLE, ST_EXEC} state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> function index, immediate flag,
// legality and latency class. Shared with the issue-queue block.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output logic [3:0]     func_idx,
  output logic           imm,
  output logic           legal,
  output lat_class_e     lat
);

  logic [4:0] low;
  logic       hi_zero;

  assign low     = opcode[4:0];
  assign hi_zero = ((opcode >> 5) == '0);

  always_comb begin
    func_idx = '0;
    imm      = 1'b0;
    legal    = 1'b0;
    lat      = LAT_1;
    if (hi_zero) begin
      if (low >= OP_ADD && low <= OP_SLT) begin
        legal    = 1'b1;
        func_idx = 4'(low - 5'd1);
      end else begin
        unique case (low)
          OP_ADDI:  begin legal = 1'b1; imm = 1'b1; func_idx = FUNC_ADD;  end
          OP_SUBI:  begin legal = 1'b1; imm = 1'b1; func_idx = FUNC_SUB;  end
          OP_MULI:  begin legal = 1'b1; imm = 1'b1; func_idx = FUNC_MUL;  end
          OP_DIVI:  begin legal = 1'b1; imm = 1'b1; func_idx = FUNC_DIV;  end
          OP_NANDI: begin legal = 1'b1; imm = 1'b1; func_idx = FUNC_NAND; end
          OP_XNORI: begin legal = 1'b1; imm = 1'b1; func_idx = FUNC_XNOR; end
          default:  ;
        endcase
      end
    end
    if (func_idx == FUNC_MUL) begin
      lat = LAT_MUL;
    end else if (func_idx == FUNC_DIV || func_idx == FUNC_MOD) begin
      lat = LAT_DIV;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one opcode per handshake, holds the decoded
// one-hot enable for the op's latency and pulses done on its last cycle.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int OPW     = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNTW    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPW-1:0]      opcode,
  input  logic                alu_enable,
  input  logic                flush,
  output logic [NUM_FUNC-1:0] func_en,
  output logic                imm_sel,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  localparam logic [CNTW-1:0] MUL_CNT = CNTW'(MUL_LAT - 1);
  localparam logic [CNTW-1:0] DIV_CNT = CNTW'(DIV_LAT - 1);

  state_e              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d, start_cnt;
  logic [NUM_FUNC-1:0] func_en_d;
  logic                imm_d, done_d, illegal_d;
  logic [3:0]          dec_idx;
  logic                dec_imm, dec_legal;
  lat_class_e          dec_lat;
  logic                accept, start;

  alu_op_decode #(.OPW(OPW)) u_decode (
    .opcode   (opcode),
    .func_idx (dec_idx),
    .imm      (dec_imm),
    .legal    (dec_legal),
    .lat      (dec_lat)
  );

  // In IDLE the counter is always zero, so cnt==0 alone marks a free slot.
  assign in_ready = rst_n && !flush && (state_q == ST_IDLE || cnt_q == '0);
  assign accept   = in_valid && in_ready;
  assign start    = accept && alu_enable && dec_legal;
  assign busy     = (state_q == ST_EXEC);

  always_comb begin
    start_cnt = '0;
    unique case (dec_lat)
      LAT_MUL: start_cnt = MUL_CNT;
      LAT_DIV: start_cnt = DIV_CNT;
      default: start_cnt = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func_en_d = func_en;
    imm_d     = imm_sel;
    illegal_d = 1'b0;
    if (flush) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      func_en_d = '0;
      imm_d     = 1'b0;
    end else begin
      illegal_d = accept && alu_enable && !dec_legal;
      if (state_q == ST_EXEC && cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (start) begin
        state_d   = ST_EXEC;
        cnt_d     = start_cnt;
        func_en_d = NUM_FUNC'(1) << dec_idx;
        imm_d     = dec_imm;
      end else begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        func_en_d = '0;
        imm_d     = 1'b0;
      end
    end
    // done is registered, so it marks the upcoming final execute cycle.
    done_d = (state_d == ST_EXEC) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      func_en <= '0;
      imm_sel <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_en <= func_en_d;
      imm_sel <= imm_d;
      done    <= done_d;
      illegal <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the issue rules.
module tb_alu_issue_ctrl;

  localparam int OPW     = 5;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;
  localparam int CNTW    = 5;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, alu_enable, flush;
  logic [4:0]  opcode;
  logic        in_ready, imm_sel, busy, done, illegal;
  logic [14:0] func_en;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.OPW(OPW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .alu_enable (alu_enable),
    .flush      (flush),
    .func_en    (func_en),
    .imm_sel    (imm_sel),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic       rst_n;
    logic       in_valid;
    logic       alu_enable;
    logic       flush;
    logic [4:0] opcode;
  } stim_t;

  typedef struct packed {
    logic        in_ready;
    logic [14:0] func_en;
    logic        imm_sel;
    logic        busy;
    logic        done;
    logic        illegal;
  } exp_t;

  exp_t  exp_q[$];
  stim_t dir_q[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model: the op in flight and how many enable cycles it has left.
  bit m_busy = 1'b0;
  bit m_imm = 1'b0;
  bit m_illegal = 1'b0;
  int m_func = 0;
  int m_rem = 0;

  function automatic void ref_decode(input int op, output bit legal, output int idx,
                                     output bit imm, output int lat);
    legal = 1'b0;
    idx   = 0;
    imm   = 1'b0;
    if (op >= 1 && op <= 15) begin
      legal = 1'b1;
      idx   = op - 1;
    end else if (op >= 18 && op <= 23) begin
      legal = 1'b1;
      imm   = 1'b1;
      case (op)
        18:      idx = 0;
        19:      idx = 1;
        20:      idx = 2;
        21:      idx = 3;
        22:      idx = 8;
        default: idx = 9;
      endcase
    end
    if (idx == 2)                lat = MUL_LAT;
    else if (idx == 3 || idx == 4) lat = DIV_LAT;
    else                          lat = 1;
  endfunction

  function automatic exp_t model_expect(input stim_t s);
    exp_t e;
    e.in_ready = s.rst_n && !s.flush && (!m_busy || m_rem == 1);
    e.func_en  = m_busy ? (15'(1) << m_func) : 15'h0;
    e.imm_sel  = m_busy && m_imm;
    e.busy     = m_busy;
    e.done     = m_busy && (m_rem == 1);
    e.illegal  = m_illegal;
    return e;
  endfunction

  task automatic model_step(input stim_t s);
    bit legal, imm, ready, acc;
    int idx, lat;
    ref_decode(int'(s.opcode), legal, idx, imm, lat);
    ready = s.rst_n && !s.flush && (!m_busy || m_rem == 1);
    acc   = s.in_valid && ready;
    if (!s.rst_n || s.flush) begin
      m_busy = 1'b0; m_imm = 1'b0; m_illegal = 1'b0; m_rem = 0;
    end else begin
      m_illegal = acc && s.alu_enable && !legal;
      if (m_busy && m_rem > 1) begin
        m_rem = m_rem - 1;
      end else if (acc && s.alu_enable && legal) begin
        m_busy = 1'b1; m_func = idx; m_imm = imm; m_rem = lat;
      end else begin
        m_busy = 1'b0; m_imm = 1'b0; m_rem = 0;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [14:0] act, input logic [14:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("in_ready", 15'(in_ready), 15'(e.in_ready));
    cmp("func_en",  func_en,       e.func_en);
    cmp("imm_sel",  15'(imm_sel),  15'(e.imm_sel));
    cmp("busy",     15'(busy),     15'(e.busy));
    cmp("done",     15'(done),     15'(e.done));
    cmp("illegal",  15'(illegal),  15'(e.illegal));
  endtask

  task automatic applyStimulus(input stim_t s, input bit check);
    rst_n      = s.rst_n;
    in_valid   = s.in_valid;
    alu_enable = s.alu_enable;
    flush      = s.flush;
    opcode     = s.opcode;
    if (check) exp_q.push_back(model_expect(s));
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  function automatic stim_t mk(input bit r, input bit v, input int op, input bit en, input bit f);
    stim_t s;
    s.rst_n = r; s.in_valid = v; s.opcode = 5'(op); s.alu_enable = en; s.flush = f;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int r, op;
    r = int'($urandom_range(0, 99));
    if (r < 15)      op = 18 + 4 * int'($urandom_range(0, 1)) + int'($urandom_range(0, 1));
    else if (r < 55) begin
      op = int'($urandom_range(1, 15));
      if (op >= 3 && op <= 5) op = 1;
    end
    else if (r < 65) op = ($urandom_range(0, 1) != 0) ? 3 : 20;
    else if (r < 70) op = 4 + int'($urandom_range(0, 1));
    else             op = int'($urandom_range(0, 31));
    s = mk($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 75, op,
           $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 4);
    return s;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    // reset
    dir_q.push_back(mk(0, 0, 0, 1, 0));
    dir_q.push_back(mk(0, 0, 0, 1, 0));
    // ADD held valid for three cycles
    repeat (3) dir_q.push_back(mk(1, 1, 1, 1, 0));
    dir_q.push_back(mk(1, 0, 0, 1, 0));
    // MUL followed by a waiting SUB
    dir_q.push_back(mk(1, 1, 3, 1, 0));
    repeat (4) dir_q.push_back(mk(1, 1, 2, 1, 0));
    repeat (2) dir_q.push_back(mk(1, 0, 0, 1, 0));
    // ADDI then XNORI
    dir_q.push_back(mk(1, 1, 18, 1, 0));
    dir_q.push_back(mk(1, 1, 23, 1, 0));
    repeat (2) dir_q.push_back(mk(1, 0, 0, 1, 0));
    // undefined opcode with and without enable
    dir_q.push_back(mk(1, 1, 16, 1, 0));
    dir_q.push_back(mk(1, 0, 0, 1, 0));
    dir_q.push_back(mk(1, 1, 16, 0, 0));
    repeat (2) dir_q.push_back(mk(1, 0, 0, 1, 0));
    // DIV flushed in its fifth execute cycle
    dir_q.push_back(mk(1, 1, 4, 1, 0));
    repeat (4) dir_q.push_back(mk(1, 0, 0, 1, 0));
    dir_q.push_back(mk(1, 0, 0, 1, 1));
    repeat (2) dir_q.push_back(mk(1, 0, 0, 1, 0));
    // reset during DIV
    dir_q.push_back(mk(1, 1, 4, 1, 0));
    repeat (3) dir_q.push_back(mk(1, 0, 0, 1, 0));
    dir_q.push_back(mk(0, 1, 1, 1, 0));
    repeat (2) dir_q.push_back(mk(1, 0, 0, 1, 0));

    for (int i = 0; i < dir_q.size(); i++) applyStimulus(dir_q[i], i > 0);
    for (int i = 0; i < 3000; i++) applyStimulus(rand_stim(), 1'b1);
    applyStimulus(mk(1, 0, 0, 1, 0), 1'b1);

    @(negedge clk);
    #1;
    cmp("queue_drained", 15'(exp_q.size()), 15'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle successor to the combinational ALU opcode decoder. It accepts one opcode per valid/ready handshake and decodes it to a one-hot function enable plus an immediate-form flag. It holds that enable for a per-class, parameterised latency and pulses `done` on the final cycle. It sits between the instruction-decode stage and the ALU datapath, and stalls issue while a multi-cycle MUL/DIV/MOD is in flight.

## Interface
Parameters:
- `OPW`, 5: opcode width; must be ≥5, and upper bits above 5 must be zero for a legal opcode.
- `MUL_LAT`, 4: cycles `MUL` enable is held (≥1).
- `DIV_LAT`, 16: cycles `DIV`/`MOD` enable is held (≥1).
- `CNTW`, 5: latency counter width; must hold max(`MUL_LAT`,`DIV_LAT`)−1.

Ports (one clock, `clk`; reset `rst_n` is synchronous, active-low):
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `in_valid` input 1: opcode offered.
- `in_ready` output 1: block can accept this cycle.
- `opcode` input `OPW`: operation code.
- `alu_enable` input 1: qualifies the transfer; an accepted transfer with `alu_enable`=0 is consumed and discarded.
- `flush` input 1: abort in-flight op.
- `func_en` output 15: one-hot enable, bit order ADD,SUB,MUL,DIV,MOD,MAX,MIN,NOT,NAND,XNOR,SHL,SHRL,ROL,ROR,SLT (bit 0 = ADD).
- `imm_sel` output 1: current op is immediate form.
- `busy` output 1: an op is executing.
- `done` output 1: one-cycle pulse on the last execute cycle.
- `illegal` output 1: one-cycle pulse after an undefined opcode is accepted.

## Operation
- Decode rules:
  - Opcodes 1–15 map to function index opcode−1 with `imm_sel`=0.
  - Opcodes 18–23 map to ADD, SUB, MUL, DIV, NAND, XNOR with `imm_sel`=1.
  - All other values, including 0, 16, 17 and 24–31, are illegal.
- Latency classes:
  - MUL uses `MUL_LAT`.
  - DIV and MOD use `DIV_LAT`.
  - All other functions take 1 cycle.
- States: IDLE and EXEC.
- Handshake:
  - `in_ready` = !`flush` && (IDLE || (EXEC && cnt==0)).
  - Accept = `in_valid` && `in_ready`.
- Accept of a legal opcode with `alu_enable`=1:
  - next cycle the state is EXEC, `func_en` is the decoded one-hot, `imm_sel` is set, and cnt = latency−1.
- EXEC behaviour:
  - `busy`=1 throughout.
  - cnt decrements each cycle while nonzero.
  - When cnt==0, `done`=1 that cycle.
  - Next cycle is EXEC with the new op if a transfer was accepted in that cycle; otherwise IDLE with `func_en`=0 and `imm_sel`=0.
- Accept of an illegal opcode, or any accept with `alu_enable`=0:
  - `illegal` pulses next cycle only for the illegal-with-enable case.
  - `func_en` stays 0 and the state goes to or remains IDLE.
  - An illegal accept in the `done` cycle still retires the current op normally.
- `flush`:
  - overrides everything except reset.
  - next cycle the state is IDLE, `func_en`=0, `imm_sel`=0, cnt=0, with no `done` and no `illegal`.
  - a `done` already asserted in the flush cycle stays visible in that cycle.
- `func_en` is always zero or one-hot, and is nonzero iff `busy`.

## Timing
- Reset, and the cycle after `rst_n` is sampled low:
  - state IDLE, cnt 0.
  - `func_en`=0, `imm_sel`=0, `busy`=0, `done`=0, `illegal`=0.
  - `in_ready`=0 while `rst_n` is low, and 1 in the first cycle after release.
- Reset mid-operation discards the op, with no `done`.
- Accept at edge T:
  - `func_en` valid from T+1 for exactly latency cycles.
  - `done` asserted in cycle T+latency.
- Throughput:
  - single-cycle ops sustain 1 per cycle, with `done` high continuously.
  - a MUL blocks issue for `MUL_LAT`−1 cycles.
- All outputs are registered except `in_ready`, which is combinational from state, cnt and `flush`.

## Structure
- Shared package `alu_pkg`:
  - `NUM_FUNC`=15 and the function-index constants `FUNC_ADD`..`FUNC_SLT`.
  - opcode constants `OP_ADD`=5'b00001 .. `OP_SLT`=5'b01111 and `OP_ADDI`=5'b10010 .. `OP_XNORI`=5'b10111.
  - a latency-class enum (`LAT_1`, `LAT_MUL`, `LAT_DIV`) and the state enum.
- Sub-module `alu_op_decode`: purely combinational. Maps `opcode` to {func index, imm, legal, latency class}, and is reused by the future issue-queue block.
- `alu_issue_ctrl` holds the FSM, counter, and output registers.

## Test plan
- Reset then ADD (5'b00001) held valid for 3 cycles:
  - `func_en`=15'h0001 for cycles T+1..T+3 and `done` high in all three.
  - `in_ready` stays 1.
- MUL (5'b00011) with `MUL_LAT`=4:
  - `func_en`=15'h0004 for 4 cycles and `done` only on the 4th.
  - `in_ready`=0 in the first 3 EXEC cycles.
  - a queued SUB is accepted in the 4th cycle.
- ADDI (5'b10010) then XNORI (5'b10111):
  - `func_en`=15'h0001 with `imm_sel`=1, then `func_en`=15'h0200 with `imm_sel`=1.
- Opcode 5'b10000 with `alu_enable`=1 → `illegal` pulses one cycle, `func_en` stays 0. The same opcode with `alu_enable`=0 produces no pulse.
- DIV (`DIV_LAT`=16) with `flush` at the 5th EXEC cycle → IDLE next cycle, no `done`, `func_en`=0.
- `rst_n` low during a DIV → all outputs 0 the next cycle, and `in_ready`=1 after release.
